clocking_sync_port: RTL and testbench

- Synthesizable stand-in for a clocking-block interface.
- Registers one driven signal (`a`) onto the rising clock edge and samples one input signal (`b`) at the same edge, so both sides of the block see race-free, cycle-aligned values.
- Sits between a testbench or controller and a DUT port group, with the DUT owning `b` as an output.
- Also provides a clocking-event counter so sequencers can wait N clock events.

---
 rtl/clocking_sync_port.sv | 74 +++++++
 tb/tb_clocking_sync_port.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/clocking_sync_port.sv
// Synthesizable clocking-block stand-in: registered drive of a, staged sampling of b, change pulse,
// and a saturating clock-event counter. Optional macro CB_EDGE_DETECT_EN builds the b_chg logic.
module clocking_sync_port #(
    parameter int A_W       = 1,
    parameter int B_W       = 1,
    parameter int IN_STAGES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [A_W-1:0]   a_drv,
    input  logic             a_we,
    output logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [B_W-1:0]   cb_b,
    output logic             b_chg,
    output logic [CNT_W-1:0] evt_cnt,
    input  logic [CNT_W-1:0] evt_tgt,
    output logic             evt_hit
);

    logic [IN_STAGES-1:0][B_W-1:0] stage;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
        end else if (a_we) begin
            a <= a_drv;
        end
    end

    // Shift chain: stage 0 captures b, the last stage is the sampled view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= b;
            for (int i = 1; i < IN_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign cb_b = stage[IN_STAGES-1];

`ifdef CB_EDGE_DETECT_EN
    logic [B_W-1:0] cb_prev;

    // cb_prev starts equal to the reset value of cb_b, so reset alone never produces a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cb_prev <= '0;
            b_chg   <= 1'b0;
        end else begin
            cb_prev <= cb_b;
            b_chg   <= (cb_b != cb_prev);
        end
    end
`else
    assign b_chg = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (evt_cnt != {CNT_W{1'b1}}) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

    assign evt_hit = (evt_cnt >= evt_tgt);

endmodule

// File: tb/tb_clocking_sync_port.sv
// Self-checking bench for clocking_sync_port: table-driven drive/sample vectors on a 1-stage instance,
// plus hand-written async-reset, 3-stage latency and 4-bit counter saturation sequences.
module tb_clocking_sync_port;

`ifdef CB_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a_drv, a_we, b;
    logic        a, cb_b, b_chg, evt_hit;
    logic [15:0] evt_cnt, evt_tgt;

    logic        a3_drv, a3_we, b3;
    logic        a3, cb_b3, b_chg3, evt_hit3;
    logic [3:0]  evt_cnt3, evt_tgt3;

    int errors = 0;
    int checks = 0;

    clocking_sync_port #(.A_W(1), .B_W(1), .IN_STAGES(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a_drv(a_drv), .a_we(a_we), .a(a), .b(b), .cb_b(cb_b),
        .b_chg(b_chg), .evt_cnt(evt_cnt), .evt_tgt(evt_tgt), .evt_hit(evt_hit)
    );

    clocking_sync_port #(.A_W(1), .B_W(1), .IN_STAGES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .a_drv(a3_drv), .a_we(a3_we), .a(a3), .b(b3), .cb_b(cb_b3),
        .b_chg(b_chg3), .evt_cnt(evt_cnt3), .evt_tgt(evt_tgt3), .evt_hit(evt_hit3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        a_drv;
        logic        a_we;
        logic        b;
        logic [15:0] tgt;
        logic        a_e;
        logic        cb_e;
        logic        chg_e;
        logic [15:0] cnt_e;
        logic        hit_e;
    } vec_t;

    vec_t vecs[7];

    initial begin
        //          drv  we   b    tgt  a    cb   chg  cnt  hit
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd4, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 16'd6, 1'b1, 1'b1, 1'b1, 16'd6, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'd8, 1'b1, 1'b1, 1'b1, 16'd7, 1'b0};

        rst = 1'b1;
        a_drv = 1'b0; a_we = 1'b0; b = 1'b0; evt_tgt = 16'd0;
        a3_drv = 1'b0; a3_we = 1'b0; b3 = 1'b0; evt_tgt3 = 4'd15;

        // Reset state, including evt_hit with a zero target while reset is held.
        #12;
        check("rst_a", a, 1'b0);
        check("rst_cb_b", cb_b, 1'b0);
        check("rst_b_chg", b_chg, 1'b0);
        check("rst_evt_cnt", evt_cnt, 16'd0);
        check("rst_evt_hit_tgt0", evt_hit, 1'b1);
        check("rst_cnt3", evt_cnt3, 4'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            a_drv   = vecs[k].a_drv;
            a_we    = vecs[k].a_we;
            b       = vecs[k].b;
            evt_tgt = vecs[k].tgt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_a", k + 1), a, vecs[k].a_e);
            check($sformatf("vec%0d_cb_b", k + 1), cb_b, vecs[k].cb_e);
            check($sformatf("vec%0d_b_chg", k + 1), b_chg, vecs[k].chg_e & EDGE_EN);
            check($sformatf("vec%0d_evt_cnt", k + 1), evt_cnt, vecs[k].cnt_e);
            check($sformatf("vec%0d_evt_hit", k + 1), evt_hit, vecs[k].hit_e);
        end

        // Asynchronous reset between edges with a=1, cb_b=1, evt_cnt=7.
        #2;
        rst = 1'b1;
        evt_tgt = 16'd0;
        #1;
        check("async_rst_a", a, 1'b0);
        check("async_rst_cb_b", cb_b, 1'b0);
        check("async_rst_b_chg", b_chg, 1'b0);
        check("async_rst_evt_cnt", evt_cnt, 16'd0);
        check("async_rst_evt_hit", evt_hit, 1'b1);

        // a_we during reset must not load a.
        a_drv = 1'b1;
        a_we  = 1'b1;
        b     = 1'b0;
        @(posedge clk);
        #1;
        check("rst_we_a", a, 1'b0);
        check("rst_we_cnt", evt_cnt, 16'd0);

        @(negedge clk);
        rst  = 1'b0;
        a_we = 1'b0;
        b3   = 1'b1;

        // Counting from release, 3-stage latency, and 4-bit saturation.
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("seq%0d_evt_cnt", k), evt_cnt, k);
            check($sformatf("seq%0d_evt_cnt3", k), evt_cnt3, (k > 15) ? 15 : k);
            check($sformatf("seq%0d_evt_hit3", k), evt_hit3, (k >= 15) ? 1'b1 : 1'b0);
            if (k <= 5) begin
                check($sformatf("seq%0d_cb_b3", k), cb_b3, (k >= 3) ? 1'b1 : 1'b0);
                check($sformatf("seq%0d_b_chg3", k), b_chg3, (k == 4) ? EDGE_EN : 1'b0);
            end
            if (k <= 2) begin
                check($sformatf("seq%0d_no_reset_pulse", k), b_chg, 1'b0);
                check($sformatf("seq%0d_a_hold", k), a, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
